// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: digit feed from the ID sequencer plus the active-low 8-digit display pins.
interface seg7_scan_display_if;
  logic [3:0] digit_in;
  logic digit_valid;
  logic dp_in;
  logic CA, CB, CC, CD, CE, CF, CG, DP;
  logic [7:0] AN;
  modport master(output digit_in, digit_valid, dp_in, input CA, CB, CC, CD, CE, CF, CG, DP, AN);
  modport slave(input digit_in, digit_valid, dp_in, output CA, CB, CC, CD, CE, CF, CG, DP, AN);
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: 8-digit shift-in BCD buffer scanned onto a multiplexed active-low 7-segment display.
// Define SEG7_LEADING_ZERO_BLANK_EN to keep slots that have not yet been filled fully dark.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 100000
) (
  input logic clk100M,
  input logic sys_rst_n,
  seg7_scan_display_if.slave bus
);
  localparam int PW = REFRESH_DIV > 2 ? $clog2(REFRESH_DIV) : 1;
  logic [PW-1:0] presc;
  logic [2:0] idx;
  logic [7:0][3:0] slot;
  logic [3:0] fill;
  logic tick;
  logic dark;
  logic [3:0] cur;
  logic [6:0] dec;
  logic [7:0] an_q;
  logic [6:0] seg_q;
  logic dp_q;
  assign tick = presc == PW'(REFRESH_DIV - 1);
  assign cur = slot[idx];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign dark = {1'b0, idx} >= fill;
`else
  assign dark = 1'b0;
`endif
  always_comb begin
    dec = 7'b1111111;
    case (cur)
      4'd0: dec = 7'b0000001;
      4'd1: dec = 7'b1001111;
      4'd2: dec = 7'b0010010;
      4'd3: dec = 7'b0000110;
      4'd4: dec = 7'b1001100;
      4'd5: dec = 7'b0100100;
      4'd6: dec = 7'b0100000;
      4'd7: dec = 7'b0001111;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0000100;
      default: dec = 7'b1111111;
    endcase
  end
  always_ff @(posedge clk100M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc <= '0;
      idx <= '0;
      slot <= '0;
      fill <= '0;
      an_q <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) idx <= idx + 3'd1;
      if (bus.digit_valid) begin
        slot <= {slot[6:0], bus.digit_in};
        fill <= fill == 4'd8 ? fill : fill + 4'd1;
      end
      // outputs follow the pre-edge idx/buffer, giving one clock of pin latency
      an_q <= dark ? 8'hFF : ~(8'd1 << idx);
      seg_q <= dark ? 7'h7F : dec;
      dp_q <= dark | ~(bus.dp_in & (idx == 3'd0));
    end
  end
  assign bus.AN = an_q;
  assign {bus.CA, bus.CB, bus.CC, bus.CD, bus.CE, bus.CF, bus.CG} = seg_q;
  assign bus.DP = dp_q;
endmodule
